// File: rtl/ws2812b_pkg.sv
// Shared types and default timing for the WS2812B transmitter.
// Default timings assume a 27 MHz clock.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BIT,
        LATCH
    } state_t;

    localparam int DEF_NUM_LEDS     = 1;
    localparam int DEF_T0H_CYCLES   = 10;
    localparam int DEF_T1H_CYCLES   = 19;
    localparam int DEF_BIT_CYCLES   = 34;
    localparam int DEF_RESET_CYCLES = 8100;

    localparam int WORD_BITS = 24;
    localparam int FIRST_BIT = WORD_BITS - 1;

    // Field order is the wire order: green MSB leaves first, blue LSB last.
    typedef struct packed {
        logic [7:0] green;
        logic [7:0] red;
        logic [7:0] blue;
    } grb_t;

    function automatic grb_t pack_grb(input logic [7:0] red, input logic [7:0] green,
                                      input logic [7:0] blue);
        grb_t word;
        word.green = green;
        word.red   = red;
        word.blue  = blue;
        return word;
    endfunction

endpackage

// File: rtl/ws2812b_if.sv
// Handshake and pin bundle between the colour source and the WS2812B transmitter.
interface ws2812b_if;

    logic       i_send;
    logic [7:0] i_red;
    logic [7:0] i_green;
    logic [7:0] i_blue;
    logic       o_dout;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_send, i_red, i_green, i_blue,
        input  o_dout, o_busy, o_done
    );

    modport slave (
        input  i_send, i_red, i_green, i_blue,
        output o_dout, o_busy, o_done
    );

endinterface

// File: rtl/ws2812b_bit_encoder.sv
// Produces one WS2812B bit waveform of BIT_CYCLES cycles per start strobe.
// A start on the last cycle chains the next bit with no gap on the line.
module ws2812b_bit_encoder
    import ws2812b_pkg::*;
#(
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic dout,
    output logic last_cycle
);

    localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] HIGH0    = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] HIGH1    = CYC_W'(T1H_CYCLES);

    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_next;
    logic             active;
    logic             bit_q;

    assign cyc_next   = cyc_cnt + CYC_W'(1);
    assign last_cycle = active && (cyc_cnt == CYC_LAST);

    // The line rises on start because every legal high time is at least one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            active  <= 1'b0;
            bit_q   <= 1'b0;
            dout    <= 1'b0;
        end else if (start) begin
            cyc_cnt <= '0;
            active  <= 1'b1;
            bit_q   <= bit_val;
            dout    <= 1'b1;
        end else if (last_cycle) begin
            cyc_cnt <= '0;
            active  <= 1'b0;
            dout    <= 1'b0;
        end else if (active) begin
            cyc_cnt <= cyc_next;
            dout    <= cyc_next < (bit_q ? HIGH1 : HIGH0);
        end
    end

endmodule

// File: rtl/ws2812b_tx.sv
// WS2812B frame transmitter: sends one GRB word to every pixel of the chain,
// then holds the line low for the latch interval before signalling done.
module ws2812b_tx
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    ws2812b_if.slave bus
);

    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          NUM_LEDS >= 1 && RESET_CYCLES >= 1)) begin : g_bad_params
        $error("ws2812b_tx: illegal timing or pixel-count parameters");
    end

    localparam int BIT_W = $clog2(FIRST_BIT) + 1;
    localparam int IDX_W = $clog2(WORD_BITS);
    localparam int LED_W = $clog2(NUM_LEDS) + 1;
    localparam int LAT_W = $clog2(RESET_CYCLES) + 1;
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(NUM_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);

    state_t           state;
    grb_t             word;
    grb_t             send_word;
    logic [BIT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [LED_W-1:0] led_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             busy_q;
    logic             done_q;
    logic             enc_start;
    logic             enc_bit;
    logic             enc_last;
    logic             enc_dout;

    // Choose the next bit to hand the encoder, including the wrap to the next pixel.
    always_comb begin
        send_word = pack_grb(bus.i_red, bus.i_green, bus.i_blue);
        bit_idx   = IDX_W'(bit_cnt - BIT_W'(1));
        enc_start = 1'b0;
        enc_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_send) begin
                    enc_start = 1'b1;
                    enc_bit   = send_word[FIRST_BIT];
                end
            end
            BIT: begin
                if (enc_last) begin
                    if (bit_cnt != '0) begin
                        enc_start = 1'b1;
                        enc_bit   = word[bit_idx];
                    end else if (led_cnt != LED_LAST) begin
                        enc_start = 1'b1;
                        enc_bit   = word[FIRST_BIT];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            word    <= '0;
            bit_cnt <= '0;
            led_cnt <= '0;
            lat_cnt <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_send) begin
                        word    <= send_word;
                        bit_cnt <= BIT_W'(FIRST_BIT);
                        led_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= BIT;
                    end
                end
                BIT: begin
                    if (enc_last) begin
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - BIT_W'(1);
                        end else if (led_cnt != LED_LAST) begin
                            led_cnt <= led_cnt + LED_W'(1);
                            bit_cnt <= BIT_W'(FIRST_BIT);
                        end else begin
                            lat_cnt <= '0;
                            state   <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ws2812b_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_encoder (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .start      (enc_start),
        .bit_val    (enc_bit),
        .dout       (enc_dout),
        .last_cycle (enc_last)
    );

    assign bus.o_dout = enc_dout;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule

// File: tb/tb_ws2812b_tx.sv
// Bench for ws2812b_tx: a frame-level timeline model checked every cycle,
// plus decoded-stream and timing measurements pinned to hand-derived values.
module tb_ws2812b_tx;

    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int BITC   = 6;
    localparam int RSTC   = 10;
    localparam int NLED   = 2;
    localparam int STREAM = 24 * NLED * BITC;
    localparam int TOTAL  = STREAM + RSTC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    ws2812b_if bus();

    int tests_run    = 0;
    int tests_failed = 0;

    bit          m_active = 1'b0;
    int          m_t      = 0;
    logic [23:0] m_word   = '0;
    logic [2:0]  exp_out;

    logic        mon_clear = 1'b0;
    int          busy_len, done_count, high_run, low_run, last_gap, bad_pulses, bits_seen;
    logic [47:0] decoded;

    logic [7:0]  rr, gg, bb;

    ws2812b_tx #(
        .NUM_LEDS     (NLED),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .BIT_CYCLES   (BITC),
        .RESET_CYCLES (RSTC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected {dout, busy, done} at cycle t of a frame carrying word w.
    function automatic logic [2:0] expect_at(input int t, input logic [23:0] w);
        int pos;
        int phase;
        if (t < STREAM) begin
            pos   = (t / BITC) % 24;
            phase = t % BITC;
            return {phase < (w[23 - pos] ? T1H : T0H), 2'b10};
        end
        if (t < TOTAL) return 3'b010;
        return 3'b001;
    endfunction

    // Advance the model by the edge just past, compare, then update the stream monitors.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (!m_active || m_t == TOTAL) begin
            if (bus.i_send === 1'b1) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = {bus.i_green, bus.i_red, bus.i_blue};
            end else begin
                m_active = 1'b0;
            end
        end else begin
            m_t++;
        end
        exp_out = m_active ? expect_at(m_t, m_word) : 3'b000;
        checkOutput("dout", 64'(bus.o_dout), 64'(exp_out[2]));
        checkOutput("busy", 64'(bus.o_busy), 64'(exp_out[1]));
        checkOutput("done", 64'(bus.o_done), 64'(exp_out[0]));

        if (mon_clear) begin
            busy_len = 0; done_count = 0; high_run = 0; low_run = 0;
            bad_pulses = 0; bits_seen = 0; decoded = '0;
        end else begin
            if (bus.o_busy) busy_len++;
            if (bus.o_done) done_count++;
            if (bus.o_dout) begin
                high_run++;
            end else if (high_run != 0) begin
                decoded = {decoded[46:0], high_run > (T0H + T1H) / 2};
                bits_seen++;
                if (high_run != T0H && high_run != T1H) bad_pulses++;
                high_run = 0;
            end
            if (!bus.o_busy) begin
                low_run++;
            end else begin
                if (low_run != 0) last_gap = low_run;
                low_run = 0;
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearMonitors();
        mon_clear = 1'b1;
        idleCycles(1);
        mon_clear = 1'b0;
    endtask

    // Holds i_send for one edge, then scrambles the don't-care colour inputs.
    task automatic applyStimulus(input logic [7:0] red, input logic [7:0] green,
                                 input logic [7:0] blue);
        bus.i_send  = 1'b1;
        bus.i_red   = red;
        bus.i_green = green;
        bus.i_blue  = blue;
        idleCycles(1);
        bus.i_send  = 1'b0;
        bus.i_red   = 8'($urandom);
        bus.i_green = 8'($urandom);
        bus.i_blue  = 8'($urandom);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (bus.o_done !== 1'b1 && n < budget) begin
            idleCycles(1);
            n++;
        end
        checkOutput("done_within_budget", 64'(bus.o_done), 64'd1);
    endtask

    initial begin
        bus.i_send  = 1'b0;
        bus.i_red   = 8'h00;
        bus.i_green = 8'h00;
        bus.i_blue  = 8'h00;
        rst_n       = 1'b0;
        idleCycles(3);
        checkOutput("reset_dout", 64'(bus.o_dout), 64'd0);
        checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
        checkOutput("reset_done", 64'(bus.o_done), 64'd0);
        rst_n = 1'b1;

        clearMonitors();
        idleCycles(20);
        checkOutput("idle_busy_cycles", 64'(busy_len), 64'd0);
        checkOutput("idle_done_count", 64'(done_count), 64'd0);
        checkOutput("idle_bits", 64'(bits_seen + high_run), 64'd0);

        $display("[TB] green-only frame");
        clearMonitors();
        applyStimulus(8'h00, 8'hFF, 8'h00);
        checkOutput("first_rise_ff", 64'(bus.o_dout), 64'd1);
        waitDone(TOTAL + 20);
        checkOutput("busy_len_ff", 64'(busy_len), 64'd298);
        checkOutput("done_count_ff", 64'(done_count), 64'd1);
        checkOutput("stream_ff", 64'(decoded), 64'h0000_FF00_00FF_0000);
        checkOutput("bits_ff", 64'(bits_seen), 64'd48);
        checkOutput("pulse_width_ff", 64'(bad_pulses), 64'd0);

        $display("[TB] mixed colour frame");
        idleCycles(3);
        clearMonitors();
        applyStimulus(8'hA5, 8'h3C, 8'h81);
        checkOutput("first_rise_mixed", 64'(bus.o_dout), 64'd1);
        waitDone(TOTAL + 20);
        checkOutput("stream_mixed", 64'(decoded), 64'h0000_3CA5_813C_A581);
        checkOutput("busy_len_mixed", 64'(busy_len), 64'd298);

        $display("[TB] send while busy");
        idleCycles(2);
        clearMonitors();
        applyStimulus(8'h34, 8'h12, 8'h56);
        idleCycles(50);
        applyStimulus(8'hEE, 8'hDD, 8'hCC);
        waitDone(TOTAL + 20);
        checkOutput("stream_ignored_send", 64'(decoded), 64'h0000_1234_5612_3456);
        checkOutput("busy_len_ignored_send", 64'(busy_len), 64'd298);
        checkOutput("done_count_ignored_send", 64'(done_count), 64'd1);

        $display("[TB] back-to-back frames");
        idleCycles(2);
        clearMonitors();
        applyStimulus(8'h0F, 8'hF0, 8'h55);
        waitDone(TOTAL + 20);
        applyStimulus(8'h81, 8'h18, 8'h7E);
        checkOutput("b2b_busy_gap", 64'(last_gap), 64'd1);
        waitDone(TOTAL + 20);
        checkOutput("stream_b2b", 64'(decoded), 64'h0000_1881_7E18_817E);
        checkOutput("done_count_b2b", 64'(done_count), 64'd2);
        checkOutput("busy_len_b2b", 64'(busy_len), 64'd596);

        $display("[TB] reset mid-frame");
        idleCycles(2);
        applyStimulus(8'hFF, 8'hFF, 8'hFF);
        idleCycles(32);
        rst_n = 1'b0;
        idleCycles(1);
        checkOutput("midreset_dout", 64'(bus.o_dout), 64'd0);
        checkOutput("midreset_busy", 64'(bus.o_busy), 64'd0);
        rst_n = 1'b1;
        clearMonitors();
        idleCycles(TOTAL + 50);
        checkOutput("midreset_no_done", 64'(done_count), 64'd0);
        checkOutput("midreset_no_busy", 64'(busy_len), 64'd0);
        applyStimulus(8'h01, 8'h80, 8'hC3);
        waitDone(TOTAL + 20);
        checkOutput("stream_after_reset", 64'(decoded), 64'h0000_8001_C380_01C3);

        $display("[TB] randomized frames");
        for (int k = 0; k < 8; k++) begin
            rr = 8'($urandom);
            gg = 8'($urandom);
            bb = 8'($urandom);
            applyStimulus(rr, gg, bb);
            if ($urandom_range(0, 1) == 1) begin
                idleCycles(int'($urandom_range(1, 250)));
                applyStimulus(8'($urandom), 8'($urandom), 8'($urandom));
            end
            waitDone(TOTAL + 20);
            checkOutput("stream_random", 64'(decoded), 64'({gg, rr, bb, gg, rr, bb}));
            if ($urandom_range(0, 2) != 0) idleCycles(int'($urandom_range(1, 6)));
        end

        idleCycles(5);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
